// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared frame geometry and FSM state encoding for the 3-wire SPI master
package adc_spi_pkg;
  localparam int FRAME_W = 16;
  localparam int RW_BIT = 15;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int TURNAROUND_EDGE = 8;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP, S_ARM} state_e;
endpackage

// File: rtl/spi_sclk_tick.sv
// spi_sclk_tick: CLK_DIV half-period divider emitting SCLK rise/fall strobes, restarted by start_i
module spi_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic ph_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic ph_q, ph_d, tick;
  assign tick = en_i && cnt_q == CW'(CLK_DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + CW'(en_i);
  assign ph_d = ph_q ^ tick;
  assign rise_o = tick && !ph_q;
  assign fall_o = tick && ph_q;
  assign ph_o = ph_q;
  // phase starts high so the setup half-period ends in a fall strobe and shifting begins low
  always_ff @(posedge clk) begin
    if (rst || start_i) begin
      cnt_q <= '0;
      ph_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      ph_q <= ph_d;
    end
  end
endmodule

// File: rtl/adc_spi3w_master.sv
// adc_spi3w_master: 3-wire SPI master for single register writes/reads (read path under ADC_SPI_READ_EN)
module adc_spi3w_master
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_write,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              cmd_write_ack,
  output logic              cmd_read_ack,
  output logic [DATA_W-1:0] read_data,
  output logic              spi_ce,
  output logic              spi_sclk,
  output logic              spi_dir,
  output logic              spi_out,
  input  logic              spi_in
);
  state_e state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic rw_q, rw_d, wack_q, rack_q, start, rise, fall, ph;
  logic [3:0] bit_q, bit_d;
  logic [7:0] gap_q, gap_d;
`ifdef ADC_SPI_READ_EN
  logic [DATA_W-1:0] rx_q, rx_d, rd_q;
`endif
  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk), .rst(rst), .start_i(start),
    .en_i(state_q inside {S_SETUP, S_SHIFT, S_HOLD}),
    .rise_o(rise), .fall_o(fall), .ph_o(ph)
  );
  // frame sequencing: latch request, shift 16 bits, hold, ack, enforce CE gap, wait for request release
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    rw_d = rw_q;
    bit_d = bit_q;
    gap_d = gap_q;
    start = 1'b0;
`ifdef ADC_SPI_READ_EN
    rx_d = rx_q;
`endif
    case (state_q)
      S_IDLE: if (cmd_write || cmd_read) begin
        rw_d = !cmd_write;
        sr_d = cmd_write ? {1'b0, write_addr, write_data} : {1'b1, read_addr, {DATA_W{1'b0}}};
`ifdef ADC_SPI_READ_EN
        start = 1'b1;
        state_d = S_SETUP;
`else
        start = cmd_write;
        state_d = cmd_write ? S_SETUP : S_DONE;
`endif
      end
      S_SETUP: if (fall) begin
        state_d = S_SHIFT;
        bit_d = '0;
      end
      S_SHIFT: begin
`ifdef ADC_SPI_READ_EN
        if (rise) rx_d = {rx_q[DATA_W-2:0], spi_in};
`endif
        if (fall) begin
          sr_d = {sr_q[FRAME_W-2:0], 1'b0};
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'(FRAME_W - 1)) state_d = S_HOLD;
        end
      end
      S_HOLD: if (rise) state_d = S_DONE;
      S_DONE: begin
        gap_d = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == 8'(CE_GAP - 1)) state_d = S_ARM;
      end
      S_ARM: if (!cmd_write && !cmd_read) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state registers; acks are a one-cycle registered image of DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q <= '0;
      rw_q <= 1'b0;
      bit_q <= '0;
      gap_q <= '0;
      wack_q <= 1'b0;
      rack_q <= 1'b0;
`ifdef ADC_SPI_READ_EN
      rx_q <= '0;
      rd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      rw_q <= rw_d;
      bit_q <= bit_d;
      gap_q <= gap_d;
      wack_q <= state_q == S_DONE && !rw_q;
      rack_q <= state_q == S_DONE && rw_q;
`ifdef ADC_SPI_READ_EN
      rx_q <= rx_d;
      if (state_q == S_DONE && rw_q) rd_q <= rx_q;
`endif
    end
  end
  assign cmd_write_ack = wack_q;
  assign cmd_read_ack = rack_q;
  assign spi_ce = !(state_q inside {S_SETUP, S_SHIFT, S_HOLD});
  assign spi_sclk = state_q == S_SHIFT && ph;
  assign spi_out = !spi_ce && sr_q[RW_BIT];
`ifdef ADC_SPI_READ_EN
  assign spi_dir = !(rw_q && ((state_q == S_SHIFT && bit_q >= 4'(TURNAROUND_EDGE)) || state_q == S_HOLD));
  assign read_data = rd_q;
`else
  logic unused_spi_in;
  assign unused_spi_in = spi_in;
  assign spi_dir = 1'b1;
  assign read_data = '0;
`endif
endmodule
